// File: rtl/quad_step_decoder.sv
`default_nettype none
// quad_step_decoder: synchronised, glitch-filtered A/B quadrature decoder producing step/dir, position and error count.
// Revision 1.0
module quad_step_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int POS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 quad_a,
  input  logic                 quad_b,
  input  logic                 en,
  input  logic                 clr,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic [POS_WIDTH-1:0] pos,
  output logic [7:0]           err_cnt
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [3:0]           C_CNT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [7:0]           C_ERR_MAX  = 8'hFF;
  localparam logic [POS_WIDTH-1:0] C_POS_ONE  = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [1:0]           sync1_q, s2_q, s2_prev_q;
  logic [1:0]           filt_q, filt_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 fwd_q, fwd_d, rev_q, rev_d, bad_q, bad_d;
  logic                 step_q, step_d, dir_q, dir_d, err_q, err_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 stable, accept;
  logic [1:0]           delta;

  // {b,a} is the Gray code of the position within the forward cycle 00->10->11->01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[0], ab[0] ^ ab[1]};
  endfunction

  // In INIT a steady pair counts even if it matches filt, so a quiet encoder still gets a reference.
  assign stable = (s2_q == s2_prev_q) && ((s2_q != filt_q) || (state_q == ST_INIT));
  assign accept = stable && (cnt_q == C_CNT_LAST);
  assign delta  = gray_idx(s2_q) - gray_idx(filt_q);

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    cnt_d   = 4'd0;
    fwd_d   = 1'b0;
    rev_d   = 1'b0;
    bad_d   = 1'b0;
    if (accept) begin
      filt_d = s2_q;
      if (state_q == ST_INIT) begin
        state_d = ST_TRACK;
      end else begin
        fwd_d = (delta == 2'd1);
        rev_d = (delta == 2'd3);
        bad_d = (delta == 2'd2);
      end
    end else if (stable) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    step_d    = en & (fwd_q | rev_q);
    err_d     = en & bad_q;
    dir_d     = step_d ? fwd_q : dir_q;
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      pos_d     = '0;
      err_cnt_d = 8'd0;
    end else begin
      if (en & fwd_q) pos_d = pos_q + C_POS_ONE;
      if (en & rev_q) pos_d = pos_q - C_POS_ONE;
      if (err_d && (err_cnt_q != C_ERR_MAX)) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 2'b00;
      s2_q      <= 2'b00;
      s2_prev_q <= 2'b00;
      filt_q    <= 2'b00;
      cnt_q     <= 4'd0;
      state_q   <= ST_INIT;
      fwd_q     <= 1'b0;
      rev_q     <= 1'b0;
      bad_q     <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      sync1_q   <= {quad_a, quad_b};
      s2_q      <= sync1_q;
      s2_prev_q <= s2_q;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      fwd_q     <= fwd_d;
      rev_q     <= rev_d;
      bad_q     <= bad_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign err     = err_q;
  assign pos     = pos_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// tb_quad_step_decoder: scenario tasks plus randomized phases checked against a transition-table model.
// Revision 1.0
module tb_quad_step_decoder;

  localparam int FL = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n, quad_a, quad_b, en, clr;
  logic          step, dir, err;
  logic [PW-1:0] pos;
  logic [7:0]    err_cnt;

  quad_step_decoder #(.FILTER_LEN(FL), .POS_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .en(en), .clr(clr),
    .step(step), .dir(dir), .err(err), .pos(pos), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int mon_steps = 0, mon_errs = 0, mon_run = 0, mon_maxrun = 0, last_step_edge = 0;
  always @(negedge clk) begin
    if (step === 1'b1) begin
      mon_steps++;
      last_step_edge = edge_cnt;
      mon_run++;
      if (mon_run > mon_maxrun) mon_maxrun = mon_run;
    end else begin
      mon_run = 0;
    end
    if (err === 1'b1) mon_errs++;
  end

  // Reference model: accepted pair, position, error count and pulse totals.
  logic [1:0] m_ref;
  logic       m_dir = 1'b0;
  int         m_pos = 0, m_errcnt = 0, m_steps = 0, m_errs = 0;

  function automatic int seq_idx(input logic [1:0] v);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic m_step(input logic [1:0] v, input logic e);
    int d;
    if (v != m_ref) begin
      d = (seq_idx(v) - seq_idx(m_ref) + 4) % 4;
      if (e) begin
        if (d == 2) begin
          m_errs++;
          if (m_errcnt < 255) m_errcnt++;
        end else begin
          m_steps++;
          m_dir = (d == 1);
          m_pos = (d == 1) ? (m_pos + 1) % 256 : (m_pos + 255) % 256;
        end
      end
      m_ref = v;
    end
  endtask

  task automatic m_reset(input logic [1:0] v);
    m_ref = v; m_dir = 1'b0; m_pos = 0; m_errcnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v);
    {quad_a, quad_b} = v;
  endtask

  task automatic hard_reset(input logic [1:0] v);
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; drive(v);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    m_reset(v);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; drive(2'b11);
    tick(3);
    n_cmp++;
    if ({step, dir, err, pos, err_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", {step, dir, err, pos, err_cnt});
    end
    rst_n = 1'b1;
    tick(20);
    m_reset(2'b11);
    n_cmp++;
    if (mon_steps != m_steps || mon_errs != m_errs) begin
      n_bad++; $display("FAIL reset_init_quiet: got steps=%0d errs=%0d expected %0d/%0d", mon_steps, mon_errs, m_steps, m_errs);
    end
    n_cmp++;
    if (pos !== 8'd0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_init_pos: got pos=%0d err=%b expected 0/0", pos, err);
    end
    drive(2'b01); m_step(2'b01, 1'b1); tick(10);
    n_cmp++;
    if (mon_steps != m_steps || pos !== m_pos[7:0]) begin
      n_bad++; $display("FAIL reset_tracking: got steps=%0d pos=%0d expected %0d/%0d", mon_steps, pos, m_steps, m_pos);
    end
  endtask

  task automatic test_forward;
    logic [1:0] ph [4];
    int e0;
    ph = '{2'b10, 2'b11, 2'b01, 2'b00};
    hard_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      e0 = edge_cnt + 1;
      drive(ph[i]); m_step(ph[i], 1'b1); tick(10);
      n_cmp++;
      if (last_step_edge - e0 != FL + 3 || mon_steps != m_steps) begin
        n_bad++; $display("FAIL fwd_latency[%0d]: got latency=%0d steps=%0d expected %0d/%0d", i, last_step_edge - e0, mon_steps, FL + 3, m_steps);
      end
      n_cmp++;
      if (dir !== 1'b1) begin
        n_bad++; $display("FAIL fwd_dir[%0d]: got %b expected 1", i, dir);
      end
    end
    n_cmp++;
    if (pos !== 8'd4 || pos !== m_pos[7:0] || mon_maxrun != 1) begin
      n_bad++; $display("FAIL fwd_pos: got pos=%0d width=%0d expected 4/1", pos, mon_maxrun);
    end
  endtask

  task automatic test_reverse;
    clr = 1'b1; tick(1); clr = 1'b0; m_pos = 0; m_errcnt = 0;
    drive(2'b01); m_step(2'b01, 1'b1); tick(10);
    n_cmp++;
    if (pos !== 8'd255 || dir !== 1'b0 || mon_steps != m_steps) begin
      n_bad++; $display("FAIL rev_wrap: got pos=%0d dir=%b steps=%0d expected 255/0/%0d", pos, dir, mon_steps, m_steps);
    end
    drive(2'b00); m_step(2'b00, 1'b1); tick(10);
    n_cmp++;
    if (pos !== 8'd0 || pos !== m_pos[7:0]) begin
      n_bad++; $display("FAIL rev_unwrap: got pos=%0d expected 0", pos);
    end
  endtask

  task automatic test_glitch;
    int s0, p0;
    s0 = mon_steps; p0 = m_pos;
    drive(2'b10); tick(4); drive(2'b00); tick(12);
    n_cmp++;
    if (mon_steps != s0 || mon_errs != m_errs || pos !== p0[7:0]) begin
      n_bad++; $display("FAIL glitch_short: got steps=%0d errs=%0d pos=%0d expected %0d/%0d/%0d", mon_steps, mon_errs, pos, s0, m_errs, p0);
    end
    drive(2'b10); m_step(2'b10, 1'b1); tick(6);
    drive(2'b00); m_step(2'b00, 1'b1); tick(12);
    n_cmp++;
    if (mon_steps != s0 + 2 || mon_steps != m_steps || pos !== p0[7:0] || mon_maxrun != 1) begin
      n_bad++; $display("FAIL glitch_long: got steps=%0d pos=%0d width=%0d expected %0d/%0d/1", mon_steps, pos, mon_maxrun, s0 + 2, p0);
    end
  endtask

  task automatic test_illegal;
    int s0, e0;
    clr = 1'b1; tick(1); clr = 1'b0; m_pos = 0; m_errcnt = 0;
    s0 = mon_steps; e0 = mon_errs;
    drive(2'b11); m_step(2'b11, 1'b1); tick(10);
    n_cmp++;
    if (mon_errs != e0 + 1 || err_cnt !== 8'd1 || mon_steps != s0) begin
      n_bad++; $display("FAIL illegal_once: got errs=%0d err_cnt=%0d steps=%0d expected %0d/1/%0d", mon_errs, err_cnt, mon_steps, e0 + 1, s0);
    end
    for (int i = 1; i < 300; i++) begin
      drive(m_ref ^ 2'b11); m_step(m_ref ^ 2'b11, 1'b1); tick(10);
    end
    n_cmp++;
    if (err_cnt !== 8'd255 || err_cnt !== m_errcnt[7:0] || mon_errs != m_errs) begin
      n_bad++; $display("FAIL illegal_saturate: got err_cnt=%0d errs=%0d expected 255/%0d", err_cnt, mon_errs, m_errs);
    end
  endtask

  task automatic test_enable;
    logic [1:0] ph [3];
    int s0, p0, e0;
    ph = '{2'b10, 2'b11, 2'b01};
    s0 = mon_steps; p0 = m_pos;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(ph[i]); m_step(ph[i], 1'b0); tick(10);
    end
    n_cmp++;
    if (mon_steps != s0 || pos !== p0[7:0]) begin
      n_bad++; $display("FAIL en_off: got steps=%0d pos=%0d expected %0d/%0d", mon_steps, pos, s0, p0);
    end
    en = 1'b1;
    drive(2'b00); m_step(2'b00, 1'b1); tick(10);
    n_cmp++;
    if (mon_steps != s0 + 1 || pos !== m_pos[7:0] || m_pos != (p0 + 1) % 256) begin
      n_bad++; $display("FAIL en_resume: got steps=%0d pos=%0d expected %0d/%0d", mon_steps, pos, s0 + 1, (p0 + 1) % 256);
    end
    e0 = edge_cnt + 1;
    drive(2'b10); m_step(2'b10, 1'b1);
    tick(FL + 3);
    clr = 1'b1; tick(1); clr = 1'b0;
    m_pos = 0; m_errcnt = 0;
    n_cmp++;
    if (step !== 1'b1 || pos !== 8'd0 || err_cnt !== 8'd0 || edge_cnt != e0 + FL + 3) begin
      n_bad++; $display("FAIL clr_vs_step: got step=%b pos=%0d err_cnt=%0d expected 1/0/0", step, pos, err_cnt);
    end
    tick(5);
  endtask

  task automatic test_reset_mid;
    drive(m_ref ^ 2'b10); tick(3);
    rst_n = 1'b0; tick(1);
    n_cmp++;
    if ({step, dir, err, pos, err_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_mid: got %h expected 0", {step, dir, err, pos, err_cnt});
    end
    rst_n = 1'b1; tick(20);
    m_reset({quad_a, quad_b});
    drive(m_ref ^ 2'b10); m_step(m_ref ^ 2'b10, 1'b1); tick(10);
    n_cmp++;
    if (mon_steps != m_steps || pos !== m_pos[7:0] || dir !== m_dir) begin
      n_bad++; $display("FAIL reset_mid_reentry: got steps=%0d pos=%0d dir=%b expected %0d/%0d/%b", mon_steps, pos, dir, m_steps, m_pos, m_dir);
    end
  endtask

  task automatic test_random;
    logic [1:0] v;
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        drive(2'($urandom_range(0, 3)));
        tick($urandom_range(1, FL));
      end
      v = 2'($urandom_range(0, 3));
      drive(v); m_step(v, en);
      tick($urandom_range(10, 14));
      if ($urandom_range(0, 9) == 0) begin
        clr = 1'b1; tick(1); clr = 1'b0; m_pos = 0; m_errcnt = 0;
      end
      n_cmp++;
      if (pos !== m_pos[7:0] || err_cnt !== m_errcnt[7:0] || dir !== m_dir) begin
        n_bad++; $display("FAIL rand_state[%0d]: got pos=%0d err_cnt=%0d dir=%b expected %0d/%0d/%b", i, pos, err_cnt, dir, m_pos, m_errcnt, m_dir);
      end
      n_cmp++;
      if (mon_steps != m_steps || mon_errs != m_errs) begin
        n_bad++; $display("FAIL rand_pulses[%0d]: got steps=%0d errs=%0d expected %0d/%0d", i, mon_steps, mon_errs, m_steps, m_errs);
      end
    end
    n_cmp++;
    if (mon_maxrun != 1) begin
      n_bad++; $display("FAIL step_width: got %0d expected 1", mon_maxrun);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; quad_a = 1'b0; quad_b = 1'b0;
    test_reset;
    test_forward;
    test_reverse;
    test_glitch;
    test_illegal;
    test_enable;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
